// File: rtl/mem_arbiter.sv
// Round-robin arbiter that serialises instruction fetches and data loads/stores
// onto one backing-memory port, one transaction at a time, with a response watchdog.
module mem_arbiter #(
    parameter int XLEN    = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [AW-1:0]     i_req_addr,
    output logic              i_resp_valid,
    output logic [XLEN-1:0]   i_resp_data,
    output logic              i_resp_err,

    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [AW-1:0]     d_req_addr,
    input  logic              d_req_wen,
    input  logic [XLEN-1:0]   d_req_wdata,
    input  logic [XLEN/8-1:0] d_req_wmask,
    output logic              d_resp_valid,
    output logic [XLEN-1:0]   d_resp_data,
    output logic              d_resp_err,

    output logic              m_req_valid,
    input  logic              m_req_ready,
    output logic [AW-1:0]     m_req_addr,
    output logic              m_req_wen,
    output logic [XLEN-1:0]   m_req_wdata,
    output logic [XLEN/8-1:0] m_req_wmask,
    input  logic              m_resp_valid,
    input  logic [XLEN-1:0]   m_resp_data
);
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t          r_state;
    logic            r_last_d;
    logic            r_owner_d;
    logic            r_wen;
    logic [7:0]      r_wdog;

    logic            w_idle;
    logic            w_grant_i;
    logic            w_grant_d;
    logic [AW-1:0]   w_sel_addr;
    logic [XLEN-1:0] w_cap_data;
    logic            w_finish;
    logic [XLEN-1:0] w_fin_data;
    logic            w_fin_err;

    // Ready is withheld while reset is asserted so no handshake is lost to it.
    assign w_idle      = reset && (r_state == S_IDLE);
    assign w_grant_i   = w_idle && i_req_valid && (!d_req_valid || r_last_d);
    assign w_grant_d   = w_idle && d_req_valid && (!i_req_valid || !r_last_d);
    assign i_req_ready = w_grant_i;
    assign d_req_ready = w_grant_d;

    assign w_sel_addr  = w_grant_d ? d_req_addr : i_req_addr;
    assign w_cap_data  = r_wen ? '0 : m_resp_data;

    // A response coinciding with the watchdog expiry wins over the timeout.
    always_comb begin
        w_finish   = 1'b0;
        w_fin_data = '0;
        w_fin_err  = 1'b0;
        case (r_state)
            S_REQ: begin
                if (m_req_ready && m_resp_valid) begin
                    w_finish   = 1'b1;
                    w_fin_data = w_cap_data;
                end
            end
            S_WAIT: begin
                if (m_resp_valid) begin
                    w_finish   = 1'b1;
                    w_fin_data = w_cap_data;
                end else if (r_wdog == WD_LAST) begin
                    w_finish   = 1'b1;
                    w_fin_err  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_last_d     <= 1'b1;
            r_owner_d    <= 1'b0;
            r_wen        <= 1'b0;
            r_wdog       <= '0;
            i_resp_valid <= 1'b0;
            i_resp_data  <= '0;
            i_resp_err   <= 1'b0;
            d_resp_valid <= 1'b0;
            d_resp_data  <= '0;
            d_resp_err   <= 1'b0;
            m_req_valid  <= 1'b0;
            m_req_addr   <= '0;
            m_req_wen    <= 1'b0;
            m_req_wdata  <= '0;
            m_req_wmask  <= '0;
        end else begin
            i_resp_valid <= 1'b0;
            i_resp_data  <= '0;
            i_resp_err   <= 1'b0;
            d_resp_valid <= 1'b0;
            d_resp_data  <= '0;
            d_resp_err   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_grant_i || w_grant_d) begin
                        r_owner_d   <= w_grant_d;
                        r_last_d    <= w_grant_d;
                        r_wen       <= w_grant_d && d_req_wen;
                        m_req_valid <= 1'b1;
                        m_req_addr  <= w_sel_addr & ~(AW'(3));
                        m_req_wen   <= w_grant_d && d_req_wen;
                        m_req_wdata <= w_grant_d ? d_req_wdata : '0;
                        m_req_wmask <= w_grant_d ? d_req_wmask : '0;
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (m_req_ready) begin
                        m_req_valid <= 1'b0;
                        m_req_addr  <= '0;
                        m_req_wen   <= 1'b0;
                        m_req_wdata <= '0;
                        m_req_wmask <= '0;
                        r_wdog      <= '0;
                        r_state     <= w_finish ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_finish) begin
                        r_state <= S_RESP;
                    end else begin
                        r_wdog <= r_wdog + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_finish) begin
                if (r_owner_d) begin
                    d_resp_valid <= 1'b1;
                    d_resp_data  <= w_fin_data;
                    d_resp_err   <= w_fin_err;
                end else begin
                    i_resp_valid <= 1'b1;
                    i_resp_data  <= w_fin_data;
                    i_resp_err   <= w_fin_err;
                end
            end
        end
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter directly downstream of the core's instruction and data memory ports. It accepts fetch requests from the instruction port and load/store requests from the data port, serialises them onto one shared backing-memory port with a valid/ready request handshake and a variable-latency response, and returns each response to the port that issued it. The block has one outstanding transaction at a time, round-robin arbitration, and a response watchdog.

## Interface
- `XLEN`, default 32: data width.
- `AW`, default 32: address width.
- `TIMEOUT`, default 255: maximum wait for `m_resp_valid`, in cycles; 8-bit counter; legal range 1..255.

- `clk`  in  1  clock. One clock domain; everything samples on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `i_req_valid`  in  1  fetch request.
- `i_req_ready`  out  1  fetch request accepted this cycle.
- `i_req_addr`  in  AW  fetch address.
- `i_resp_valid`  out  1  fetch response, one-cycle pulse.
- `i_resp_data`  out  XLEN  fetched word.
- `i_resp_err`  out  1  fetch timed out; qualified by `i_resp_valid`.
- `d_req_valid`  in  1  data request.
- `d_req_ready`  out  1  data request accepted this cycle.
- `d_req_addr`  in  AW  data address.
- `d_req_wen`  in  1  1 = store, 0 = load.
- `d_req_wdata`  in  XLEN  store data.
- `d_req_wmask`  in  XLEN/8  store byte enables.
- `d_resp_valid`  out  1  data response pulse; loads and stores both get one.
- `d_resp_data`  out  XLEN  load data; 0 for stores.
- `d_resp_err`  out  1  data access timed out.
- `m_req_valid`  out  1  backing-memory request.
- `m_req_ready`  in  1  backing memory accepts the request.
- `m_req_addr`  out  AW  word-aligned address (bits [1:0] forced to 0).
- `m_req_wen`  out  1  store flag.
- `m_req_wdata`  out  XLEN  store data.
- `m_req_wmask`  out  XLEN/8  byte enables.
- `m_resp_valid`  in  1  backing-memory response.
- `m_resp_data`  in  XLEN  response data.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- **IDLE**
  - `i_req_ready` and `d_req_ready` are high only in IDLE, and only for the port granted this cycle. At most one is high.
  - Grant rule: with a single valid port, that port is granted. With both valid, the port not granted last time wins.
  - `last_grant` resets to data, so the first tie goes to the instruction port.
  - On accept: latch owner, address, wen, wdata and wmask (fetches latch wen=0, wmask=0); update `last_grant`; go to REQ.
- **REQ**
  - `m_req_valid` is high and the latched fields are driven, held stable until `m_req_ready`.
  - On `m_req_ready` with no response in the same cycle: go to WAIT and clear the watchdog.
  - On `m_req_ready` with `m_resp_valid` in the same cycle: capture the data and go straight to RESP.
  - `m_resp_valid` without `m_req_ready` is ignored.
- **WAIT**
  - The watchdog increments each cycle.
  - On `m_resp_valid`: capture `m_resp_data` (0 if the transaction is a store); err=0; go to RESP.
  - When the watchdog reaches `TIMEOUT` with no response: data=0, err=1, go to RESP.
  - A response arriving in the same cycle as the timeout counts as a normal response (err=0).
- **RESP**
  - The owner's `*_resp_valid` is high for exactly one cycle, with the captured data and err registered.
  - The other port's outputs stay 0. Next state is IDLE.
- `m_resp_valid` in IDLE or RESP is dropped. No state change, no output change.
- Request inputs are not sampled outside IDLE. Upstream keeps valid asserted until it sees ready.

## Timing
- Reset (`reset`=0 at an edge): next cycle state=IDLE, `last_grant`=data, watchdog=0. All outputs are 0: every ready, valid, err, data, and all `m_req_*`.
- Reset mid-transaction abandons the transaction. No response pulse is ever produced for it, and a late `m_resp_valid` lands in IDLE and is ignored.
- `*_req_ready` is combinational from state, valid and `last_grant`. All other outputs are registered.
- Minimum latency: accept at cycle 0; `m_req_valid` at cycle 1 with ready and response in the same cycle; `*_resp_valid` at cycle 2. The next accept is at cycle 3.
- With a response N≥1 cycles after acceptance, `*_resp_valid` is at cycle 2+N.
- Timeout: acceptance at cycle a; the err response pulses at cycle a+TIMEOUT+2.

## Test plan
- **Single fetch.** Fetch to 0x100; memory ready and responds 0xDEADBEEF with zero added latency. Required: `i_req_ready` at cycle 0, `m_req_addr`=0x100 at cycle 1, `i_resp_valid` with 0xDEADBEEF, err=0 at cycle 2.
- **Store.** Store to 0x203 with wdata 0x11223344, wmask 0b0011. Required: `m_req_addr`=0x200, wen=1, mask 0b0011; `d_resp_valid` with data=0. Hold `m_req_ready` low 3 cycles: `m_req_*` stays stable throughout.
- **Simultaneous requests.** Both ports valid continuously from reset. Required: grants alternate I, D, I, D; each response goes only to its owner, never a double pulse.
- **Timeout.** Load, no `m_resp_valid`, TIMEOUT=4. Required: `d_resp_valid`=1, `d_resp_err`=1, data=0 exactly 6 cycles after accept; a late `m_resp_valid` afterwards causes no output.
- **Reset mid-op.** Assert reset while in WAIT, then deliver `m_resp_valid`. Required: no `*_resp_valid` pulse; all outputs 0; the next fetch proceeds normally.
- **Spurious response.** Pulse `m_resp_valid` while IDLE. Required: no state change and no response.
